// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre sampling, DV strobe and framing-error strobe.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each sample point.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_RX_START_BIT = 3'd1,
    s_RX_DATA_BITS = 3'd2,
    s_RX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4,
    s_WAIT_IDLE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    r_Clock_Count, clock_count_d;
  logic [IDX_W-1:0]    r_Bit_Index, bit_index_d;
  logic [DATA_W-1:0]   r_Shift, shift_d;
  logic [DATA_W-1:0]   rx_byte_d;
  logic                rx_dv_d, frame_err_d, active_d;
  logic                rx_meta, rx_s;
  logic                sample_c;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // rx_hist[0] is rx_s one cycle back, rx_hist[1] two cycles back
  logic [1:0] rx_hist;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  always_comb begin
    sample_c = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
  end
`else
  always_comb begin
    sample_c = rx_s;
  end
`endif

  // State and datapath registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q        <= s_IDLE;
      r_Clock_Count  <= '0;
      r_Bit_Index    <= '0;
      r_Shift        <= '0;
      o_Rx_Byte      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
    end else begin
      state_q        <= state_d;
      r_Clock_Count  <= clock_count_d;
      r_Bit_Index    <= bit_index_d;
      r_Shift        <= shift_d;
      o_Rx_Byte      <= rx_byte_d;
      o_Rx_DV        <= rx_dv_d;
      o_Rx_Frame_Err <= frame_err_d;
      o_Rx_Active    <= active_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    clock_count_d = r_Clock_Count;
    bit_index_d   = r_Bit_Index;
    shift_d       = r_Shift;
    rx_byte_d     = o_Rx_Byte;
    rx_dv_d       = 1'b0;
    frame_err_d   = 1'b0;
    active_d      = o_Rx_Active;

    case (state_q)
      s_IDLE: begin
        clock_count_d = '0;
        bit_index_d   = '0;
        if (!rx_s) begin
          state_d  = s_RX_START_BIT;
          active_d = 1'b1;
        end
      end

      s_RX_START_BIT: begin
        if (r_Clock_Count == HALF_CNT) begin
          clock_count_d = '0;
          if (!sample_c) begin
            state_d = s_RX_DATA_BITS;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch
            state_d  = s_IDLE;
            active_d = 1'b0;
          end
        end else begin
          clock_count_d = r_Clock_Count + CNT_W'(1);
        end
      end

      s_RX_DATA_BITS: begin
        if (r_Clock_Count == LAST_CNT) begin
          clock_count_d         = '0;
          shift_d[r_Bit_Index]  = sample_c;
          if (r_Bit_Index == LAST_IDX) begin
            bit_index_d = '0;
            state_d     = s_RX_STOP_BIT;
          end else begin
            bit_index_d = r_Bit_Index + IDX_W'(1);
          end
        end else begin
          clock_count_d = r_Clock_Count + CNT_W'(1);
        end
      end

      s_RX_STOP_BIT: begin
        if (r_Clock_Count == LAST_CNT) begin
          clock_count_d = '0;
          if (sample_c) begin
            rx_byte_d = r_Shift;
            rx_dv_d   = 1'b1;
            state_d   = s_CLEANUP;
          end else begin
            frame_err_d = 1'b1;
            active_d    = 1'b0;
            state_d     = s_WAIT_IDLE;
          end
        end else begin
          clock_count_d = r_Clock_Count + CNT_W'(1);
        end
      end

      s_CLEANUP: begin
        active_d = 1'b0;
        state_d  = s_IDLE;
      end

      // A held-low line (break) must return high before the next start is accepted
      s_WAIT_IDLE: begin
        active_d = 1'b0;
        if (rx_s) begin
          state_d = s_IDLE;
        end
      end

      default: begin
        active_d = 1'b0;
        state_d  = s_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a pin-history reference model.
// The model honours UART_RX_MAJORITY_EN when the bench is built with it.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pin;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_fe;
  logic       rx_act;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_Serial   (pin),
    .o_Rx_DV       (rx_dv),
    .o_Rx_Byte     (rx_byte),
    .o_Rx_Frame_Err(rx_fe),
    .o_Rx_Active   (rx_act)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         fe;
    logic [7:0] b;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         both_cnt = 0;
  int         act_rise = -1;
  int         act_fall = -1;
  logic       act_prev = 1'b0;
  bit         pin_hist [0:32767];
  logic [7:0] last_good = 8'h00;

  // Output monitor: records strobes and activity edges at the falling edge
  always @(negedge clk) begin
    ev_t e;
    if (rst_n === 1'b1) begin
      if (rx_dv === 1'b1) begin
        e.cyc = cyc; e.fe = 1'b0; e.b = rx_byte;
        obs_q.push_back(e);
      end
      if (rx_fe === 1'b1) begin
        e.cyc = cyc; e.fe = 1'b1; e.b = rx_byte;
        obs_q.push_back(e);
      end
      if (rx_dv === 1'b1 && rx_fe === 1'b1) both_cnt++;
    end
    if (rx_act === 1'b1 && act_prev !== 1'b1) act_rise = cyc;
    if (rx_act !== 1'b1 && act_prev === 1'b1) act_fall = cyc;
    act_prev = rx_act;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pin = v;
      if (cyc < 32768) pin_hist[cyc] = v;
    end
  endtask

  // Drive one frame; k returns the cycle the start bit first appears on the pin
  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_off,
                            input int abort_at, output int k);
    logic v;
    int   j;
    k = -1;
    for (int c = 0; c < 10 * C; c++) begin
      if (c == abort_at) return;
      j = c / C;
      if (j == 0)      v = 1'b0;
      else if (j == 9) v = stop;
      else             v = d[j-1];
      if (c == spike_off) v = ~v;
      @(posedge clk); #1;
      pin = v;
      if (cyc < 32768) pin_hist[cyc] = v;
      if (c == 0) k = cyc;
    end
  endtask

  // Receiver's view of the line at pin cycle c
  function automatic logic smp(input int c);
`ifdef UART_RX_MAJORITY_EN
    logic a, b, d;
    a = pin_hist[c-2]; b = pin_hist[c-1]; d = pin_hist[c];
    return (a & b) | (a & d) | (b & d);
`else
    return pin_hist[c];
`endif
  endfunction

  // Reference model: the frame starting at pin cycle k yields a DV/FE event two sync cycles
  // plus start-half-bit plus nine bit times later, or nothing if the start bit is rejected
  function automatic void model_frame(input int k);
    ev_t        e;
    logic [7:0] b;
    if (smp(k + H + 1)) return;
    for (int i = 0; i < 8; i++) b[i] = smp(k + H + 1 + (i + 1) * C);
    e.cyc = k + H + 4 + 9 * C;
    if (smp(k + H + 1 + 9 * C)) begin
      e.fe = 1'b0; e.b = b; last_good = b;
    end else begin
      e.fe = 1'b1; e.b = last_good;
    end
    exp_q.push_back(e);
  endfunction

  task automatic check_events(input string tag);
    chk({tag, " events"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, " cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, " kind"}, 32'(obs_q[i].fe), 32'(exp_q[i].fe));
      chk({tag, " byte"}, 32'(obs_q[i].b), 32'(exp_q[i].b));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dv"}, 32'(rx_dv), 32'h0);
    chk({tag, " byte"}, 32'(rx_byte), 32'h0);
    chk({tag, " fe"}, 32'(rx_fe), 32'h0);
    chk({tag, " active"}, 32'(rx_act), 32'h0);
  endtask

  initial begin
    int         k, k2, gap;
    logic [7:0] d;
    logic       stop, prev_stop;

    for (int i = 0; i < 32768; i++) pin_hist[i] = 1'b1;
    rst_n = 1'b0;
    pin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 2 * C);

    // Clean frame: DV at T0+153, active T0+1..T0+153
    send_frame(8'hA5, 1'b1, -1, -1, k);
    drive(1'b1, 2 * C);
    model_frame(k);
    chk("a5 dv time", obs_q.size() > 0 ? obs_q[0].cyc : -1, k + 2 + 153);
    chk("a5 byte", 32'(rx_byte), 32'hA5);
    chk("a5 active rise", act_rise, k + 3);
    chk("a5 active fall", act_fall, k + 2 + 154);
    check_events("a5");

    // Three-cycle low glitch is rejected at the start-bit check
    drive(1'b0, 3);
    k = cyc - 2;
    drive(1'b1, 2 * C);
    chk("glitch strobes", obs_q.size(), 0);
    chk("glitch active rise", act_rise, k + 3);
    chk("glitch active fall", act_fall, k + 3 + H + 1);
    send_frame(8'h3C, 1'b1, -1, -1, k);
    drive(1'b1, 2 * C);
    model_frame(k);
    check_events("3c");

    // Low stop bit followed by a long break
    send_frame(8'h55, 1'b0, -1, -1, k);
    drive(1'b0, 40 * C);
    model_frame(k);
    chk("break active fall", act_fall, k + 2 + 153);
    chk("break byte held", 32'(rx_byte), 32'h3C);
    drive(1'b1, 2 * C);
    check_events("break");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, -1, -1, k);
    send_frame(8'hFF, 1'b1, -1, -1, k2);
    drive(1'b1, 2 * C);
    model_frame(k);
    model_frame(k2);
    chk("b2b spacing", obs_q.size() > 1 ? obs_q[1].cyc - obs_q[0].cyc : -1, 160);
    check_events("b2b");

    // Reset during data bit 4 aborts the frame
    send_frame(8'hC3, 1'b1, -1, 5 * C + 4, k);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pin   = 1'b1;
    pin_hist[cyc] = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    drive(1'b1, 3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pin_hist[cyc] = 1'b1;
    last_good = 8'h00;
    drive(1'b1, 2 * C);
    chk("aborted strobes", obs_q.size(), 0);
    send_frame(8'h81, 1'b1, -1, -1, k);
    drive(1'b1, 2 * C);
    model_frame(k);
    chk("after reset byte", 32'(rx_byte), 32'h81);
    check_events("81");

    // One-cycle spike at the bit-2 sample point
    send_frame(8'hF0, 1'b1, H + 1 + 3 * C, -1, k);
    drive(1'b1, 2 * C);
    model_frame(k);
`ifdef UART_RX_MAJORITY_EN
    chk("spike byte", 32'(rx_byte), 32'hF0);
`else
    chk("spike byte", 32'(rx_byte), 32'hF4);
`endif
    check_events("spike");

    // Random frames, random gaps, occasional framing errors
    prev_stop = 1'b1;
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = prev_stop ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      if (gap > 0) drive(1'b1, gap);
      send_frame(d, stop, -1, -1, k);
      model_frame(k);
      prev_stop = stop;
    end
    drive(1'b1, 2 * C);
    check_events("rand");

    chk("dv fe exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames: one start bit, 8 data bits LSB first, no parity, one stop bit. It synchronises the asynchronous `i_Rx_Serial` line and samples each bit at its centre. It delivers each received byte with a one-cycle valid strobe and flags framing errors. It is the receive-side counterpart of the existing `uart_tx`, shares its `CLKS_PER_BIT` convention, and feeds host-command parsing alongside the MAX6675 temperature stream.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit, equal to f(i_Clock)/baud. Legal range 8..4095.
- `i_Clock`  in  1  system clock; all logic on rising edge.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_Rx_Serial`  in  1  asynchronous serial line; idles high.
- `o_Rx_DV`  out  1  one-cycle pulse; `o_Rx_Byte` is valid in that cycle.
- `o_Rx_Byte`  out  8  last correctly received byte; holds between strobes.
- `o_Rx_Frame_Err`  out  1  one-cycle pulse when the stop bit samples low.
- `o_Rx_Active`  out  1  high from start-bit acceptance until the frame ends (DV, error, or glitch reject).

## Operation
- Input passes through a 2-flop synchroniser; reset value of both flops is 1. All decisions use the synchronised value `rx_s`.
- Bit counter `r_Clock_Count` is 12 bits; the bit index is 3 bits; the shift register is 8 bits. `H = (CLKS_PER_BIT-1)/2`, using integer division.
- States:
  - `s_IDLE`: clear counters. If `rx_s==0`, go to `s_RX_START_BIT` and set active.
  - `s_RX_START_BIT`: count 0..H. At count==H, sample the line. If low, clear the count and go to `s_RX_DATA_BITS`. If high, treat it as a glitch: go to `s_IDLE`, drop active, and assert no strobe.
  - `s_RX_DATA_BITS`: count 0..CLKS_PER_BIT-1. At the terminal count, shift the sample into bit `r_Bit_Index` and clear the count. After index 7, go to `s_RX_STOP_BIT`.
  - `s_RX_STOP_BIT`: at the terminal count, sample the line.
    - High: load `o_Rx_Byte`, pulse `o_Rx_DV`, and go to `s_CLEANUP`.
    - Low: pulse `o_Rx_Frame_Err`, leave `o_Rx_Byte` unchanged, and go to `s_WAIT_IDLE`.
  - `s_CLEANUP`: one cycle, drop active, go to `s_IDLE`.
  - `s_WAIT_IDLE`: drop active and stay until `rx_s==1`, then go to `s_IDLE`. This prevents a held-low line (break) from retriggering.
  - Undefined state encodings go to `s_IDLE`.
- `o_Rx_DV` and `o_Rx_Frame_Err` are never high in the same cycle.

## Timing
- Reset values: `o_Rx_DV`=0, `o_Rx_Byte`=8'h00, `o_Rx_Frame_Err`=0, `o_Rx_Active`=0, state `s_IDLE`.
- Reset takes effect immediately, including mid-frame. The partial byte is discarded.
- Synchroniser latency: a pin edge appears on `rx_s` 2 clocks later.
- Frame latency: let T0 be the first cycle `s_IDLE` sees `rx_s==0`.
  - `o_Rx_DV` is high in cycle T0 + 1 + (H+1) + 9*CLKS_PER_BIT.
  - For CLKS_PER_BIT=16 (H=7), that is T0+153.
  - `o_Rx_Frame_Err` follows the same timing.
- `o_Rx_Active` rises in cycle T0+1. It falls 1 cycle after `o_Rx_DV`, or in the `o_Rx_Frame_Err` cycle.
- Back-to-back frames: a start bit that begins immediately after the stop bit is accepted. `s_CLEANUP` consumes 1 cycle, which is well inside the half-bit margin.
- No backpressure. The consumer must capture `o_Rx_Byte` on `o_Rx_DV`; the next valid byte overwrites it.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: every start, data, and stop sample is the 2-of-3 majority of `rx_s` at counts target-2, target-1, and target, where target is H for the start bit and CLKS_PER_BIT-1 otherwise. A single-cycle spike at the sample point is rejected.
  - Undefined: the single value of `rx_s` at the target count is used.
- Latency is identical either way.

## Test plan
- CLKS_PER_BIT=16, send 8'hA5 with a valid stop bit -> exactly one `o_Rx_DV` pulse at T0+153 with `o_Rx_Byte`=8'hA5, `o_Rx_Frame_Err` never high, `o_Rx_Active` high T0+1..T0+153.
- Drive the line low for 3 cycles, then high -> `o_Rx_Active` pulses and drops after the start-bit check; no DV, no frame error; the receiver then accepts 8'h3C normally.
- Send 8'h55 with a low stop bit, then hold the line low for 40 bit times -> one `o_Rx_Frame_Err` pulse, no DV, `o_Rx_Byte` keeps its previous value, no further strobes until the line returns high.
- Send 8'h00 then 8'hFF back-to-back with no idle gap -> two DV pulses 160 cycles apart, with bytes 8'h00 then 8'hFF.
- Assert `i_Rst_n`=0 during data bit 4 of 8'hC3, release it, then send 8'h81 -> all outputs are at reset values during reset, no strobe for the aborted frame, and `o_Rx_Byte`=8'h81 on the next DV.
- With `UART_RX_MAJORITY_EN`, send 8'hF0 with a 1-cycle inverted spike at the bit-2 sample point -> `o_Rx_Byte`=8'hF0. Without the macro, the same stimulus -> 8'hF4.
